// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush sequencer for the 5-stage pipeline (load-use, redirect, memory wait, halt).
module pipe_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int          XLEN        = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_use_hazard,
    input  logic            redirect_req,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            dmem_req,
    input  logic            dmem_ready,
    input  logic            halt_req,
    output logic            pc_en,
    output logic            if_id_en,
    output logic            id_ex_en,
    output logic            ex_mem_en,
    output logic            mem_wb_en,
    output logic            if_id_flush,
    output logic            id_ex_flush,
    output logic            pc_sel,
    output logic [XLEN-1:0] pc_target,
    output logic            halted,
    output logic            bus_error,
    output logic [31:0]     stall_cycles
);
    typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_t;

    state_t          r_state, w_next;
    logic            r_pend_valid;
    logic [XLEN-1:0] r_pend_pc;
    logic [31:0]     r_wait_cnt, r_stall_cycles;
    logic [4:0]      w_en;
    logic            w_mem_stall, w_timeout;

    assign w_mem_stall = dmem_req & ~dmem_ready;
    assign w_timeout   = (MEM_TIMEOUT != 0) && (r_wait_cnt == MEM_TIMEOUT) && !dmem_ready;

    // w_en order: pc, if_id, id_ex, ex_mem, mem_wb
    always_comb begin
        w_en        = '1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        pc_sel      = 1'b0;
        pc_target   = '0;
        bus_error   = 1'b0;
        w_next      = r_state;
        case (r_state)
            RUN: begin
                if (w_mem_stall) begin
                    w_en   = '0;
                    w_next = MEM_WAIT;
                end else if (halt_req) begin
                    w_en        = 5'b01111;
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    w_next      = HALT;
                end else if (redirect_req) begin
                    pc_sel      = 1'b1;
                    pc_target   = redirect_pc;
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end else if (load_use_hazard) begin
                    w_en        = 5'b00111;
                    id_ex_flush = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (!dmem_ready) begin
                    w_en      = '0;
                    bus_error = w_timeout;
                    w_next    = w_timeout ? HALT : MEM_WAIT;
                end else begin
                    w_next = RUN;
                    if (r_pend_valid) begin
                        pc_sel      = 1'b1;
                        pc_target   = r_pend_pc;
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (load_use_hazard) begin
                        w_en        = 5'b00111;
                        id_ex_flush = 1'b1;
                    end
                end
            end
            HALT: begin
                w_en        = w_mem_stall ? 5'b00000 : 5'b00011;
                if_id_flush = 1'b1;
            end
            default: w_next = RUN;
        endcase
    end

    assign {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = w_en;
    assign halted       = (r_state == HALT);
    assign stall_cycles = r_stall_cycles;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= RUN;
            r_pend_valid   <= 1'b0;
            r_pend_pc      <= '0;
            r_wait_cnt     <= '0;
            r_stall_cycles <= '0;
        end else begin
            r_state <= w_next;
            if (!pc_en && r_stall_cycles != 32'hFFFF_FFFF)
                r_stall_cycles <= r_stall_cycles + 32'd1;
            case (r_state)
                RUN: begin
                    if (w_mem_stall) begin
                        r_wait_cnt <= 32'd1;
                        if (redirect_req) begin
                            r_pend_valid <= 1'b1;
                            r_pend_pc    <= redirect_pc;
                        end
                    end
                end
                MEM_WAIT: begin
                    r_wait_cnt <= r_wait_cnt + 32'd1;
                    if (dmem_ready || w_timeout)
                        r_pend_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule
